// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: op codes, sequencer states and the
// buffered command word.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_SHL = 3'd4,
    ALU_SHR = 3'd5,
    ALU_ROL = 3'd6,
    ALU_ROR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    alu_op_e               op;
  } alu_cmd_t;

  function automatic logic is_div_by_zero(input alu_op_e op, input logic [ALU_DATA_W-1:0] b);
    return (op == ALU_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands. Push is ignored when full, pop when empty;
// only the pointers and count are reset, the storage is not.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  alu_cmd_t               wr_data,
  input  logic                   pop,
  output alu_cmd_t               rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  alu_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to a registered ALU and returns
// results in order. Define ALU_SEQ_DIV0_FLAG_EN to add the out_div0 flag.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_op,
  output logic              busy
`ifdef ALU_SEQ_DIV0_FLAG_EN
  ,
  output logic              out_div0
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_HOLD  = HOLD;

  alu_cmd_t               fifo_wr_data, fifo_rd_data;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d, out_op_q, out_op_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_valid_q, out_valid_d;
`ifdef ALU_SEQ_DIV0_FLAG_EN
  logic              out_div0_q, out_div0_d;
`endif

  // Both ports transfer on a rising edge where valid && ready; in_ready and
  // out_valid come straight from flops, and out_* stay frozen while valid && !ready.
  assign fifo_wr_data = '{a: in_a, b: in_b, op: alu_op_e'(in_op)};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    out_valid_d  = out_valid_q;
    fifo_pop     = 1'b0;
`ifdef ALU_SEQ_DIV0_FLAG_EN
    out_div0_d   = out_div0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // The ALU registered the issued operands on the previous edge.
        out_result_d = alu_result;
        out_op_d     = alu_op_q;
        out_valid_d  = 1'b1;
`ifdef ALU_SEQ_DIV0_FLAG_EN
        out_div0_d   = is_div_by_zero(alu_op_e'(alu_op_q), alu_b_q);
        if (out_div0_d) out_result_d = '1;
`endif
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) begin
      alu_a_d  = fifo_rd_data.a;
      alu_b_d  = fifo_rd_data.b;
      alu_op_d = fifo_rd_data.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_valid_q  <= 1'b0;
`ifdef ALU_SEQ_DIV0_FLAG_EN
      out_div0_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
      out_valid_q  <= out_valid_d;
`ifdef ALU_SEQ_DIV0_FLAG_EN
      out_div0_q   <= out_div0_d;
`endif
    end
  end

  assign in_ready   = !fifo_full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);
`ifdef ALU_SEQ_DIV0_FLAG_EN
  assign out_div0   = out_div0_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU; honours ALU_SEQ_DIV0_FLAG_EN.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic       out_div0;
  logic       busy;

  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int results_seen = 0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
`ifdef ALU_SEQ_DIV0_FLAG_EN
    .out_div0   (out_div0),
`endif
    .busy       (busy)
  );
`ifndef ALU_SEQ_DIV0_FLAG_EN
  assign out_div0 = 1'b0;
`endif

  // Free-running registered ALU seen by the DUT.
  always_ff @(posedge clk) begin
    case (alu_op)
      3'd0: alu_result <= alu_a + alu_b;
      3'd1: alu_result <= alu_a - alu_b;
      3'd2: alu_result <= alu_a * alu_b;
      3'd3: alu_result <= (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
      3'd4: alu_result <= {alu_a[6:0], 1'b0};
      3'd5: alu_result <= {1'b0, alu_a[7:1]};
      3'd6: alu_result <= {alu_a[6:0], alu_a[7]};
      default: alu_result <= {alu_a[0], alu_a[7:1]};
    endcase
  end

  function automatic logic [EW-1:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
    int ia, ib, r;
    logic d0;
    ia = int'(a);
    ib = int'(b);
    d0 = 1'b0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia * ib;
      3'd3: if (ib == 0) begin r = 255; d0 = 1'b1; end else r = ia / ib;
      3'd4: r = ia * 2;
      3'd5: r = ia / 2;
      3'd6: r = ia * 2 + ia / 128;
      default: r = ia / 2 + (ia % 2) * 128;
    endcase
    r = ((r % 256) + 256) % 256;
    return {op, r[7:0], d0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic rand_cmd(output logic [7:0] a, output logic [7:0] b, output logic [2:0] op);
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 3'($urandom_range(0, 7));
`ifdef ALU_SEQ_DIV0_FLAG_EN
    if ($urandom_range(0, 5) == 0) b = 8'd0;
`else
    if (op == 3'd3 && b == 8'd0) b = 8'd1;
`endif
  endtask

  // Called just after a rising edge; returns 2 time units after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit done;
    bit rdy;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) begin
        exp_q.push_back(ref_model(a, b, op));
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance expected in_ready within 300 cycles");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(n < 400), 32'(1));
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    logic          pv, pr;
    logic [EW-1:0] pout, got, e;
    pv   = 1'b0;
    pr   = 1'b0;
    pout = '0;
    forever begin
      @(negedge clk);
      got = {out_op, out_result, out_div0};
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) check("hold_stable", 32'({out_valid, got}), 32'({1'b1, pout}));
        if (out_valid && out_ready) begin
          results_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            check("result", 32'(got), 32'(e));
          end
        end
        pv   = out_valid;
        pr   = out_ready;
        pout = got;
      end
    end
  end

  initial begin : ready_randomizer
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] ra, rb;
    logic [2:0] rop;
    int seen0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_alu_bus", 32'({alu_a, alu_b, alu_op}), 32'(0));
    check("rst_out_bus", 32'({out_result, out_op}), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single add with latency check.
    out_ready = 1'b1;
    send(8'd200, 8'd100, 3'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("add_latency", 32'(out_valid), 32'(i == 3));
    end
    wait_drain();

    // Ordered burst.
    send(8'd15, 8'd17, 3'd2);
    send(8'h81, 8'd0, 3'd6);
    send(8'h80, 8'd0, 3'd5);
    send(8'd5, 8'd6, 3'd1);
    wait_drain();

    // Backpressure: one command in HOLD plus a full FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rand_cmd(ra, rb, rop);
      send(ra, rb, rop);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'(0));
      check("full_count", 32'(dut.u_fifo.count), 32'(DEPTH));
    end
    @(posedge clk);
    #2;
    rand_cmd(ra, rb, rop);
    fork
      begin
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
      send(ra, rb, rop);
    join
    wait_drain();

    // Simultaneous push and pop at count 2.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_cmd(ra, rb, rop);
      send(ra, rb, rop);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pushpop_count_before", 32'(dut.u_fifo.count), 32'(2));
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    rand_cmd(ra, rb, rop);
    send(ra, rb, rop);
    @(negedge clk);
    check("pushpop_count_after", 32'(dut.u_fifo.count), 32'(2));
    wait_drain();

`ifdef ALU_SEQ_DIV0_FLAG_EN
    send(8'd9, 8'd0, 3'd3);
    send(8'd9, 8'd2, 3'd3);
    wait_drain();
`endif

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
      end
      rand_cmd(ra, rb, rop);
      send(ra, rb, rop);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    // Reset with work queued and a result held.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_cmd(ra, rb, rop);
      send(ra, rb, rop);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen0 = results_seen;
    repeat (12) @(posedge clk);
    #2;
    check("no_stale_result", 32'(results_seen), 32'(seen0));
    check("post_rst_busy", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
